// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and leading-zero blanking helper for the binary-to-BCD converter.
// The value word is {dp, overflow, digit5..digit0}.
package bcd_pkg;
    localparam int BIN_W          = 20;
    localparam int DIGITS         = 6;
    localparam int BCD_W          = 4 * DIGITS;
    localparam int VAL_W          = BCD_W + 2;
    localparam int CNT_W          = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(999999);
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam int DP_BIT         = 25;
    localparam int OVF_BIT        = 24;
    // With the point shown, digits below this index stay visible so "0.000" keeps its zeros.
    localparam int DP_KEEP_DIGITS = 4;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd,
                                                       input logic dp);
        logic lead;
        blank_leading = bcd;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (dp && (i < DP_KEEP_DIGITS)) lead = 1'b0;
            if (lead && (bcd[4*i +: 4] == 4'd0)) blank_leading[4*i +: 4] = BCD_BLANK;
            else lead = 1'b0;
        end
    endfunction
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more.
// Purely combinational; the >=5 test guarantees the result fits in 4 bits.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with blank code 4'hF.
module bin_to_bcd_seq
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             dp_in,
    output logic             busy,
    output logic             done,
    output logic [VAL_W-1:0] value_out
);
    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dp_q, dp_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] digits;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Overflow forces all nines; blanking never touches the overflow pattern.
    always_comb begin
        if (ovf_q) begin
            digits = {DIGITS{4'h9}};
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            digits = blank_leading(bcd_q, dp_q);
`else
            digits = bcd_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        value_d = value_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    dp_d    = dp_in;
                    ovf_d   = (bin_in > MAX_VAL);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
            end
            DONE: begin
                value_d          = '0;
                value_d[BCD_W-1:0] = digits;
                value_d[OVF_BIT] = ovf_q;
                value_d[DP_BIT]  = dp_q;
                done_d           = 1'b1;
                busy_d           = 1'b0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value_out = value_q;
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the six-digit seven-segment BCD decoder.
- Produces that decoder's 26-bit value word: 24 bits of packed BCD, an overflow bit, and the decimal-point flag.
- Start/busy/done handshake; the output word is held stable between conversions.

Parameters:
BIN_W, 20, binary input width; cycles per conversion = BIN_W.
DIGITS, 6, number of BCD digits; the output word is 4*DIGITS+2 bits.
MAX_VAL, 999999, largest displayable value (10^DIGITS - 1).

Ports:
clk  input  1  system clock; rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_W  unsigned binary value; captured on the accepted start.
dp_in  input  1  decimal-point request; captured with bin_in.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when value_out updates.
value_out  output  4*DIGITS+2  [23:0] BCD digits (digit0 in [3:0]); [24] overflow; [25] decimal flag.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, busy=0, done=0, value_out=0, shift register=0, counter=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1 at edge k: capture bin_in and dp_in; clear the BCD accumulator; counter=0; go to CONV.
  - busy=1 from edge k onward.
- CONV, edges k+1..k+BIN_W, one iteration per edge:
  - Every digit >=5 gets +3.
  - Then {bcd,bin} is shifted left by 1.
  - counter increments; at counter==BIN_W-1 the state moves to DONE.
- DONE, edge k+BIN_W+1:
  - value_out latched; done=1 for exactly one cycle; busy=0; return to IDLE.
  - Latency: start sample edge to done high = BIN_W+1 = 21 cycles.
- Throughput: a new start may be accepted on the cycle done is high, i.e. the edge after DONE. Back-to-back conversions take 22 cycles each.
- Overflow:
  - If captured bin > MAX_VAL, the conversion still runs the full BIN_W cycles.
  - value_out[23:0]=24'h999999 and value_out[24]=1.
  - Otherwise value_out[24]=0.
- value_out[25] = captured dp_in. It is applied in the same DONE latch and never changes mid-conversion.
- start while busy: ignored; no queueing; captured operands stay unchanged.
- Changes on bin_in/dp_in after capture: no effect.
- Reset mid-conversion: aborts immediately; all outputs return to reset values; no done pulse.
- value_out changes only at the DONE edge or on reset; it is glitch-free for the decoder.
- Arithmetic: each add-3 is a 4-bit add; no carry between digits (guaranteed by the >=5 test). The accumulator is 4*DIGITS bits.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - At the DONE latch, each leading zero digit, scanned from digit5 downward, is replaced by 4'hF. The downstream decoder renders 4'hF as a blank digit.
  - digit0 is never blanked.
  - If the captured dp flag is 1, digits 3..0 are never blanked, so a zero is shown before the point.
  - Overflow output (999999) is unaffected.
- Undefined: leading zeros are output as 4'h0; no extra logic.

Decomposition:
- Shared package bcd_pkg holds:
  - BIN_W, DIGITS, MAX_VAL.
  - BCD_BLANK=4'hF.
  - State enum {IDLE, CONV, DONE}.
  - Bit-field indices for the 26-bit value word: DP_BIT=25, OVF_BIT=24.
- One sub-module, bcd_add3: combinational 4-bit "if >=5 add 3" digit corrector, instantiated DIGITS times inside the CONV datapath.

Test Plan:
- Reset, then start with bin_in=123456, dp_in=0 -> done pulses 21 cycles after the start edge; value_out=26'h0123456; busy high for 21 cycles.
- bin_in=0, dp_in=1 -> value_out=26'h2000000.
  - With LEADING_ZERO_BLANK_EN: value_out={1'b1,1'b0,24'hFF0000}.
- bin_in=999999 -> value_out[23:0]=24'h999999, [24]=0; bin_in=1000000 -> 24'h999999 with [24]=1.
- start=1 with bin_in=42; hold start high and change bin_in=7 during CONV -> one conversion result of 24'h000042, then a second conversion (start still high after done) producing 24'h000007.
  - With LEADING_ZERO_BLANK_EN: first result is 24'hFFFF42.
- Assert reset at cycle 10 of a conversion of 654321 -> busy=0, value_out=0, no done pulse. A subsequent start with 654321 -> 24'h654321.
- Back-to-back: start=1 on the cycle done is high, with bin_in=1048575 -> accepted; overflow result 24'h999999 with [24]=1, 22 cycles after the previous done.
